// File: rtl/arbitro_merge_pkg.sv
// ---------------------------------------------------------------------------
// arbitro_merge_pkg
// Shared constants for the merge arbiter: word format, port count, port-index
// width and the FSM state encodings. The routing arbiter and the testers use
// the same values.
//   DATA_W    : 12-bit word width
//   NUM_IN    : 4 input FIFOs (the design supports exactly 4)
//   SEL_W     : 2-bit port index
//   ST_INIT   : first cycle after reset release, no pop
//   ST_IDLE   : nothing eligible
//   ST_ACTIVE : a grant was issued
// ---------------------------------------------------------------------------
package arbitro_merge_pkg;

  localparam int DATA_W = 12;
  localparam int NUM_IN = 4;
  localparam int SEL_W  = 2;

  localparam logic [1:0] ST_INIT   = 2'd0;
  localparam logic [1:0] ST_IDLE   = 2'd1;
  localparam logic [1:0] ST_ACTIVE = 2'd2;

  // Round-robin pointer advance; the 2-bit wrap gives 3 -> 0 for free.
  function automatic logic [SEL_W-1:0] next_ptr(input logic [SEL_W-1:0] idx);
    return idx + SEL_W'(1);
  endfunction

endpackage

// File: rtl/arbitro_merge_rr_grant.sv
// ---------------------------------------------------------------------------
// arbitro_merge_rr_grant
// Combinational picker for the merge arbiter.
//   req     in  [3:0]  eligible ports
//   ptr     in  [1:0]  round-robin start port
//   gnt     out [3:0]  one-hot grant (zero when nothing requested)
//   gnt_idx out [1:0]  index of the granted port (0 when nothing requested)
//   any     out        at least one port requested
// Configuration macro ARB_STRICT_PRIO_EN: when defined, fixed priority
// 0 > 1 > 2 > 3 and ptr is ignored; otherwise round robin from ptr.
// ---------------------------------------------------------------------------
module arbitro_merge_rr_grant
  import arbitro_merge_pkg::*;
(
  input  logic [NUM_IN-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [NUM_IN-1:0] gnt,
  output logic [SEL_W-1:0]  gnt_idx,
  output logic              any
);

`ifdef ARB_STRICT_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;
`endif

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment, otherwise synthesis infers a latch.
  always_comb begin
    gnt_idx = '0;
    any     = |req;
    // Scanning from the last candidate down to the first lets the first
    // requesting candidate overwrite all later ones.
    for (int k = NUM_IN - 1; k >= 0; k--) begin
`ifdef ARB_STRICT_PRIO_EN
      if (req[k]) gnt_idx = SEL_W'(k);
`else
      if (req[ptr + SEL_W'(k)]) gnt_idx = ptr + SEL_W'(k);
`endif
    end
    gnt = any ? (NUM_IN'(1) << gnt_idx) : '0;
  end

endmodule

// File: rtl/arbitro_merge.sv
// ---------------------------------------------------------------------------
// arbitro_merge
// Drains 4 input FIFOs into one output FIFO. Each cycle at most one
// non-empty input is granted and popped; the popped word (registered FIFO
// read) is pushed downstream the following cycle.
//   clk              in   clock, rising edge
//   reset            in   asynchronous, active-high reset
//   fifo_data        in   [47:0] packed FIFO read data, port i at [i*12 +: 12]
//   emptyFIFO        in   [3:0]  per-input empty flags
//   almost_fullFIFO  in   output FIFO almost full (room for one in-flight word)
//   pop              out  [3:0]  one-hot or zero read strobe
//   push             out  write strobe to the output FIFO
//   data_out         out  [11:0] pushed word, 0 when push=0
//   sel              out  [1:0]  port whose word is on data_out
// Configuration macro ARB_STRICT_PRIO_EN selects fixed priority instead of
// round robin; latency, handshake and reset behaviour are unchanged.
// ---------------------------------------------------------------------------
module arbitro_merge
  import arbitro_merge_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_IN*DATA_W-1:0] fifo_data,
  input  logic [NUM_IN-1:0]        emptyFIFO,
  input  logic                     almost_fullFIFO,
  output logic [NUM_IN-1:0]        pop,
  output logic                     push,
  output logic [DATA_W-1:0]        data_out,
  output logic [SEL_W-1:0]         sel
);

  logic [1:0]        state_q,   state_d;
  logic [SEL_W-1:0]  rr_ptr_q,  rr_ptr_d;
  logic [SEL_W-1:0]  grant_q_q, grant_q_d;
  logic              pop_q_q,   pop_q_d;

  logic [NUM_IN-1:0] req;
  logic [NUM_IN-1:0] gnt;
  logic [SEL_W-1:0]  gnt_idx;
  logic              any;

  // Nothing is eligible in INIT or while the output FIFO is almost full.
  // Reset forces INIT asynchronously, so pop drops the moment reset rises.
  assign req = (state_q != ST_INIT && !almost_fullFIFO) ? ~emptyFIFO : '0;

  arbitro_merge_rr_grant u_rr_grant (
    .req     (req),
    .ptr     (rr_ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  assign pop = gnt;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_INIT:   state_d = ST_IDLE;
      ST_IDLE,
      ST_ACTIVE: state_d = any ? ST_ACTIVE : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pop_q_d   = any;
    grant_q_d = any ? gnt_idx : grant_q_q;
`ifdef ARB_STRICT_PRIO_EN
    rr_ptr_d  = '0;
`else
    // Pointer only moves on a grant, so an almost-full stall resumes exactly
    // where arbitration left off.
    rr_ptr_d  = any ? next_ptr(gnt_idx) : rr_ptr_q;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_INIT;
      rr_ptr_q  <= '0;
      grant_q_q <= '0;
      pop_q_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      grant_q_q <= grant_q_d;
      pop_q_q   <= pop_q_d;
    end
  end

  // The input FIFOs present the popped word one cycle after pop, which lines
  // up with pop_q/grant_q here.
  assign push = pop_q_q;
  assign sel  = grant_q_q;

  always_comb begin
    data_out = '0;
    if (pop_q_q) data_out = fifo_data[32'(grant_q_q)*DATA_W +: DATA_W];
  end

endmodule
